// File: rtl/fp_mul_pkg.sv
// Shared definitions for the real_mul datapath: per-format widths, iteration counts, FSM encoding.
// Macro FP_MUL_RADIX4_EN selects radix-4 recoding (two multiplier bits per iteration).
package fp_mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mul_state_e;

   localparam int unsigned MANT_WIDTH_SP = 24;
   localparam int unsigned MANT_WIDTH_DP = 53;
   localparam int unsigned PROD_WIDTH_SP = 2 * MANT_WIDTH_SP;
   localparam int unsigned PROD_WIDTH_DP = 2 * MANT_WIDTH_DP;

`ifdef FP_MUL_RADIX4_EN
   localparam int unsigned RADIX_STEP = 2;
`else
   localparam int unsigned RADIX_STEP = 1;
`endif

   localparam int unsigned ITER_SP = (MANT_WIDTH_SP + RADIX_STEP - 1) / RADIX_STEP;
   localparam int unsigned ITER_DP = (MANT_WIDTH_DP + RADIX_STEP - 1) / RADIX_STEP;

   function automatic int unsigned iter_count(input int unsigned mant_width);
      return (mant_width + RADIX_STEP - 1) / RADIX_STEP;
   endfunction

endpackage

// File: rtl/fp_mul_step.sv
// One shift-add iteration on the partial-product register: hi += digit*A, then shift right by the radix step.
// Macro FP_MUL_RADIX4_EN selects radix-4 (digit in 0..3, 3A supplied precomputed).
module fp_mul_step
   import fp_mul_pkg::*;
#(
   parameter int unsigned MW = 24,
   parameter int unsigned MB = 24
)(
   input  logic [MW+MB-1:0] p,
   input  logic [MW-1:0]    a,
`ifdef FP_MUL_RADIX4_EN
   input  logic [MW+1:0]    a3,
`endif
   output logic [MW+MB-1:0] p_next
);

   localparam int unsigned SUM_W = MW + RADIX_STEP;

   logic [SUM_W-1:0] addend;
   logic [SUM_W-1:0] sum;

   always_comb begin
      addend = '0;
`ifdef FP_MUL_RADIX4_EN
      case (p[1:0])
         2'd1:    addend = {2'b00, a};
         2'd2:    addend = {1'b0, a, 1'b0};
         2'd3:    addend = a3;
         default: addend = '0;
      endcase
`else
      if (p[0]) addend = {1'b0, a};
`endif
      // hi stays below A, so hi + 3A fits in SUM_W bits and the shifted hi fits back in MW
      sum    = {{RADIX_STEP{1'b0}}, p[MW+MB-1:MB]} + addend;
      p_next = {sum, p[MB-1:RADIX_STEP]};
   end

endmodule

// File: rtl/fp_mant_mul_seq.sv
// Iterative shift-add mantissa multiplier with valid/ready handshakes; exact unrounded product.
// Macro FP_MUL_RADIX4_EN selects radix-4 iteration (half the latency); results are identical.
module fp_mant_mul_seq
   import fp_mul_pkg::*;
#(
   parameter int unsigned IS_DOUBLE  = 0,
   parameter int unsigned MANT_WIDTH = (IS_DOUBLE != 0) ? MANT_WIDTH_DP : MANT_WIDTH_SP,
   parameter int unsigned PROD_WIDTH = 2 * MANT_WIDTH
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [MANT_WIDTH-1:0] mant_a,
   input  logic [MANT_WIDTH-1:0] mant_b,
   input  logic                  sign_a,
   input  logic                  sign_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [PROD_WIDTH-1:0] product,
   output logic                  sign_out,
   output logic                  msb_set,
   output logic                  zero_flag
);

   localparam int unsigned ITER   = iter_count(MANT_WIDTH);
   localparam int unsigned MB     = ITER * RADIX_STEP;
   localparam int unsigned PW_EXT = MANT_WIDTH + MB;
   localparam int unsigned CNT_W  = $clog2(ITER);

   mul_state_e          state_q, state_d;
   logic                rdy_en_q;
   logic                load;
   logic [CNT_W-1:0]    cnt_q;
   logic [MANT_WIDTH-1:0] a_q;
   logic [PW_EXT-1:0]   p_q;
   logic [PW_EXT-1:0]   p_next;
   logic                sign_q;
`ifdef FP_MUL_RADIX4_EN
   logic [MANT_WIDTH+1:0] a3_q;
`endif

   fp_mul_step #(
      .MW (MANT_WIDTH),
      .MB (MB)
   ) u_step (
      .p      (p_q),
      .a      (a_q),
`ifdef FP_MUL_RADIX4_EN
      .a3     (a3_q),
`endif
      .p_next (p_next)
   );

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      load      = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = rdy_en_q;
            if (in_valid && rdy_en_q) begin
               load    = 1'b1;
               state_d = BUSY;
            end
         end
         BUSY: if (cnt_q == '0) state_d = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // rdy_en_q keeps in_ready low until the first edge after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         rdy_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         rdy_en_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         a_q    <= '0;
         p_q    <= '0;
         sign_q <= 1'b0;
`ifdef FP_MUL_RADIX4_EN
         a3_q   <= '0;
`endif
      end else if (load) begin
         cnt_q  <= CNT_W'(ITER - 1);
         a_q    <= mant_a;
         p_q    <= PW_EXT'(mant_b);
         sign_q <= sign_a ^ sign_b;
`ifdef FP_MUL_RADIX4_EN
         a3_q   <= {2'b00, mant_a} + {1'b0, mant_a, 1'b0};
`endif
      end else if (state_q == BUSY) begin
         p_q   <= p_next;
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign product   = p_q[PROD_WIDTH-1:0];
   assign sign_out  = sign_q;
   assign msb_set   = product[PROD_WIDTH-1];
   assign zero_flag = (product == '0);

endmodule

// File: tb/tb_fp_mant_mul_seq.sv
// Self-checking bench for fp_mant_mul_seq: binary32 and binary64 instances, vector table plus random ops.
module tb_fp_mant_mul_seq;

`ifdef FP_MUL_RADIX4_EN
   localparam int LAT_SP = 12;
   localparam int LAT_DP = 27;
`else
   localparam int LAT_SP = 24;
   localparam int LAT_DP = 53;
`endif

   logic clk = 1'b0;
   logic rst_n;

   logic        in_valid, in_ready, out_valid, out_ready;
   logic [23:0] mant_a, mant_b;
   logic        sign_a, sign_b, sign_out, msb_set, zero_flag;
   logic [47:0] product;

   logic         dp_in_valid, dp_in_ready, dp_out_valid, dp_out_ready;
   logic [52:0]  dp_mant_a, dp_mant_b;
   logic         dp_sign_a, dp_sign_b, dp_sign_out, dp_msb_set, dp_zero_flag;
   logic [105:0] dp_product;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   fp_mant_mul_seq #(.IS_DOUBLE(0)) dut_sp (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .mant_a(mant_a), .mant_b(mant_b), .sign_a(sign_a), .sign_b(sign_b),
      .out_valid(out_valid), .out_ready(out_ready), .product(product),
      .sign_out(sign_out), .msb_set(msb_set), .zero_flag(zero_flag)
   );

   fp_mant_mul_seq #(.IS_DOUBLE(1)) dut_dp (
      .clk(clk), .rst_n(rst_n), .in_valid(dp_in_valid), .in_ready(dp_in_ready),
      .mant_a(dp_mant_a), .mant_b(dp_mant_b), .sign_a(dp_sign_a), .sign_b(dp_sign_b),
      .out_valid(dp_out_valid), .out_ready(dp_out_ready), .product(dp_product),
      .sign_out(dp_sign_out), .msb_set(dp_msb_set), .zero_flag(dp_zero_flag)
   );

   typedef struct {
      logic [23:0] a;
      logic [23:0] b;
      logic        sa;
      logic        sb;
      logic [47:0] prod;
      logic        sign;
      logic        msb;
      logic        zero;
   } vec_t;

   vec_t vecs[7];

   task automatic check_val(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: exact unsigned product, sign is xor, flags derived from the product value
   function automatic logic [47:0] ref_sp(input logic [23:0] a, input logic [23:0] b);
      logic [47:0] wa, wb;
      wa = {24'd0, a};
      wb = {24'd0, b};
      return wa * wb;
   endfunction

   function automatic logic [105:0] ref_dp(input logic [52:0] a, input logic [52:0] b);
      logic [105:0] wa, wb;
      wa = {53'd0, a};
      wb = {53'd0, b};
      return wa * wb;
   endfunction

   task automatic sp_issue(input logic [23:0] a, input logic [23:0] b, input logic sa, input logic sb);
      int w = 0;
      while (!in_ready && w < 100) begin
         tick();
         w++;
      end
      check_bit("sp_in_ready_before_issue", in_ready, 1'b1);
      in_valid = 1'b1;
      mant_a   = a;
      mant_b   = b;
      sign_a   = sa;
      sign_b   = sb;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic sp_wait(output int lat);
      lat = 0;
      while (!out_valid && lat < 200) begin
         tick();
         lat++;
      end
   endtask

   task automatic sp_op(input string name, input logic [23:0] a, input logic [23:0] b,
                        input logic sa, input logic sb, input logic [47:0] eprod,
                        input logic esign, input logic emsb, input logic ezero);
      int lat;
      sp_issue(a, b, sa, sb);
      sp_wait(lat);
      check_int({name, "_latency"}, lat, LAT_SP);
      check_val({name, "_product"}, 128'(product), 128'(eprod));
      check_bit({name, "_sign"}, sign_out, esign);
      check_bit({name, "_msb"}, msb_set, emsb);
      check_bit({name, "_zero"}, zero_flag, ezero);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_bit({name, "_out_valid_drop"}, out_valid, 1'b0);
      check_bit({name, "_in_ready_back"}, in_ready, 1'b1);
   endtask

   task automatic dp_op(input string name, input logic [52:0] a, input logic [52:0] b,
                        input logic sa, input logic sb, input logic [105:0] eprod);
      int lat = 0;
      int w = 0;
      while (!dp_in_ready && w < 100) begin
         tick();
         w++;
      end
      dp_in_valid = 1'b1;
      dp_mant_a   = a;
      dp_mant_b   = b;
      dp_sign_a   = sa;
      dp_sign_b   = sb;
      tick();
      dp_in_valid = 1'b0;
      while (!dp_out_valid && lat < 300) begin
         tick();
         lat++;
      end
      check_int({name, "_latency"}, lat, LAT_DP);
      check_val({name, "_product"}, 128'(dp_product), 128'(eprod));
      check_bit({name, "_sign"}, dp_sign_out, sa ^ sb);
      check_bit({name, "_msb"}, dp_msb_set, eprod[105]);
      check_bit({name, "_zero"}, dp_zero_flag, eprod == 106'd0);
      dp_out_ready = 1'b1;
      tick();
      dp_out_ready = 1'b0;
      check_bit({name, "_in_ready_back"}, dp_in_ready, 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int seen;
      logic [23:0]  ra, rb;
      logic         rsa, rsb;
      logic [47:0]  rp;
      logic [52:0]  da, db;
      logic [105:0] dpp;

      vecs[0] = '{24'h800000, 24'h800000, 1'b0, 1'b0, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b1, 48'hFFFF_FE00_0001, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{24'h000000, 24'hC00000, 1'b1, 1'b0, 48'h0000_0000_0000, 1'b1, 1'b0, 1'b1};
      vecs[3] = '{24'hFFFFFF, 24'h800000, 1'b0, 1'b1, 48'h7FFF_FF80_0000, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{24'hC00000, 24'hC00000, 1'b0, 1'b0, 48'h9000_0000_0000, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{24'h000001, 24'h000001, 1'b1, 1'b1, 48'h0000_0000_0001, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{24'hC00000, 24'h000000, 1'b0, 1'b0, 48'h0000_0000_0000, 1'b0, 1'b0, 1'b1};

      rst_n = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; mant_a = '0; mant_b = '0; sign_a = 1'b0; sign_b = 1'b0;
      dp_in_valid = 1'b0; dp_out_ready = 1'b0; dp_mant_a = '0; dp_mant_b = '0;
      dp_sign_a = 1'b0; dp_sign_b = 1'b0;

      tick();
      tick();
      check_bit("rst_in_ready", in_ready, 1'b0);
      check_bit("rst_out_valid", out_valid, 1'b0);
      check_val("rst_product", 128'(product), 128'd0);
      check_bit("rst_sign_out", sign_out, 1'b0);
      check_bit("rst_msb_set", msb_set, 1'b0);
      check_bit("rst_zero_flag", zero_flag, 1'b1);
      rst_n = 1'b1;
      #1;
      check_bit("release_in_ready_before_edge", in_ready, 1'b0);
      tick();
      check_bit("release_in_ready_after_edge", in_ready, 1'b1);

      foreach (vecs[i])
         sp_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sa, vecs[i].sb,
               vecs[i].prod, vecs[i].sign, vecs[i].msb, vecs[i].zero);

      // Result held while consumer stalls; in_valid during BUSY and DONE must be ignored
      sp_issue(24'hC00000, 24'hC00000, 1'b1, 1'b0);
      in_valid = 1'b1;
      mant_a   = 24'hFFFFFF;
      mant_b   = 24'h123456;
      sp_wait(lat);
      check_int("hold_latency", lat, LAT_SP);
      for (int k = 0; k < 5; k++) begin
         check_bit($sformatf("hold%0d_out_valid", k), out_valid, 1'b1);
         check_bit($sformatf("hold%0d_in_ready", k), in_ready, 1'b0);
         check_val($sformatf("hold%0d_product", k), 128'(product), 128'h9000_0000_0000);
         check_bit($sformatf("hold%0d_sign", k), sign_out, 1'b1);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_bit("hold_release_in_ready", in_ready, 1'b1);
      check_bit("hold_release_out_valid", out_valid, 1'b0);
      tick();
      check_bit("hold_idle_no_accept", out_valid, 1'b0);

      // Abort mid-operation by reset
      sp_issue(24'h800000, 24'hC00000, 1'b1, 1'b1);
      for (int k = 0; k < 9; k++) tick();
      rst_n = 1'b0;
      #1;
      check_bit("abort_out_valid", out_valid, 1'b0);
      check_val("abort_product", 128'(product), 128'd0);
      check_bit("abort_zero_flag", zero_flag, 1'b1);
      check_bit("abort_in_ready", in_ready, 1'b0);
      tick();
      rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < LAT_SP + 4; k++) begin
         if (out_valid) seen++;
         tick();
      end
      check_int("abort_no_out_valid_pulse", seen, 0);
      sp_op("post_abort", 24'h800000, 24'h800000, 1'b0, 1'b0, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b0);

      for (int n = 0; n < 30; n++) begin
         if (n % 5 == 4) ra = 24'($urandom);
         else            ra = {1'b1, 23'($urandom)};
         if (n % 7 == 6) rb = 24'($urandom_range(0, 3));
         else            rb = {1'b1, 23'($urandom)};
         rsa = 1'($urandom);
         rsb = 1'($urandom);
         rp  = ref_sp(ra, rb);
         sp_op($sformatf("rand%0d", n), ra, rb, rsa, rsb, rp, rsa ^ rsb, rp[47], rp == 48'd0);
      end

      dp_op("dp_1p5_sq", 53'h18_0000_0000_0000, 53'h18_0000_0000_0000, 1'b0, 1'b1,
            (106'd1 << 105) | (106'd1 << 102));
      for (int n = 0; n < 3; n++) begin
         da  = {1'b1, 20'($urandom), 32'($urandom)};
         db  = {1'b1, 20'($urandom), 32'($urandom)};
         dpp = ref_dp(da, db);
         dp_op($sformatf("dp_rand%0d", n), da, db, 1'($urandom), 1'($urandom), dpp);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
